linreg_scheduler: RTL and testbench
===================================

Name: linreg_scheduler

Overview:
- Shares one combinational linear_regression datapath (size in, price/rout out) between N_REQ requesters.
- Round-robin arbitration; one request in flight at a time.
- Drives the datapath input from a register and waits a fixed settle time.
- Captures price/rout and returns them on a single tagged response channel with valid/ready.
- Sits between sensor-side request sources and the inference datapath; also keeps a saturating rout-event counter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SIZE_W, 16, size operand width.
- PRICE_W, 32, price result width.
- SETTLE, 1, cycles the datapath input is held before capture (>=1).
- CNT_W, 16, width of rout event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_size  in  N_REQ*SIZE_W  packed sizes; requester i at bits [i*SIZE_W +: SIZE_W].
- req_ready  out  N_REQ  one-hot accept strobe.
- lr_size  out  SIZE_W  registered operand to the datapath.
- lr_price  in  PRICE_W  datapath result.
- lr_rout  in  1  datapath rout flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(N_REQ)  index of the served requester.
- rsp_price  out  PRICE_W  captured price.
- rsp_rout  out  1  captured rout.
- busy  out  1  high when state != IDLE.
- rout_count  out  CNT_W  saturating count of completed responses with rsp_rout=1.

Behaviour:
- Reset values:
  - State IDLE.
  - lr_size, rsp_price, rsp_rout, rsp_id, rsp_valid, busy and rout_count all 0.
  - RR pointer last_grant = N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Combinational RR pick: the first i with req_valid[i]=1, scanning last_grant+1 upward modulo N_REQ.
  - req_ready = one-hot of the pick. It is all-zero outside IDLE and all-zero when no request is valid.
  - On the accepting edge:
    - lr_size <= req_size[pick]
    - gid <= pick
    - last_grant <= pick
    - cnt <= SETTLE-1
    - go to WAIT.
- WAIT:
  - lr_size is held.
  - If cnt==0: rsp_price <= lr_price, rsp_rout <= lr_rout, rsp_id <= gid, rsp_valid <= 1, go to RESP.
  - Otherwise cnt decrements.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On the edge where rsp_valid & rsp_ready:
    - rsp_valid <= 0
    - rout_count increments if rsp_rout=1, saturating at all-ones
    - go to IDLE.
- Latency: acceptance at edge k gives rsp_valid=1 after edge k+SETTLE.
- Throughput: minimum request-to-request spacing is SETTLE+2 cycles when rsp_ready is held high. The IDLE cycle is mandatory.
- Fairness:
  - A requester that was just served has lowest priority next round.
  - Requesters that are not valid are skipped without cost.
- Requester rule: once req_valid is high, req_size must stay stable until req_ready. The scheduler never samples size outside the accepting edge.
- rsp_valid never drops without a handshake.
- lr_size keeps its last value in IDLE; it is not cleared.
- Asynchronous reset mid-transaction aborts it:
  - no response is produced;
  - all registers return to reset values immediately;
  - the pointer is restored to N_REQ-1.
- A request arriving in WAIT or RESP waits; it is considered on the next IDLE cycle.

Decomposition:
- Shared package/include linreg_defs:
  - SIZE_W and PRICE_W defaults;
  - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- One sub-module rr_arbiter (N parameter): inputs req[N] and last_grant; output grant one-hot and grant index; purely combinational.
- The linear_regression datapath stays outside; it is instantiated next to the scheduler at the top level.

Test Plan:
- Single request, bench datapath stub price=3*size+100, rout=(size>1000): requester 0, size=217.
  - req_ready[0] pulses once.
  - lr_size=217.
  - After SETTLE edges: rsp_valid=1, rsp_id=0, rsp_price=751, rsp_rout=0.
  - rout_count stays 0.
- All four valid with sizes 10, 20, 30, 40 and rsp_ready=1:
  - Responses appear in order id 0, 1, 2, 3 with prices 130, 160, 190, 220.
  - Spacing is SETTLE+2 cycles each.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_price and rsp_id remain stable and busy=1.
  - No req_ready is asserted.
  - After rsp_ready=1, IDLE follows, then the next grant.
- Fairness: requester 1 held valid continuously and requester 2 valid once.
  - Grants go 1, 2, 1; requester 1 is never granted twice while requester 2 is pending.
- rout and saturation: size=2000 gives rsp_rout=1 and rout_count=1.
  - With CNT_W=2, five such responses leave rout_count=3.
- Reset mid-WAIT (SETTLE=3, rst_n low during cycle 2):
  - Outputs go to 0 immediately and no response is produced.
  - After release, requester 0 wins first again.

Source files
------------

// File: rtl/linreg_defs_pkg.sv
// Shared definitions for the linear-regression request scheduler.
// Holds datapath width defaults and the scheduler state encoding.
package linreg_defs;

  localparam int SIZE_W_DEF  = 16;
  localparam int PRICE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans upward from the slot after last_grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last_grant) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/linreg_scheduler.sv
// Round-robin scheduler sharing one linear-regression datapath
// between N_REQ requesters, with a tagged valid/ready response.
module linreg_scheduler
  import linreg_defs::*;
#(
  parameter int N_REQ   = 4,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int PRICE_W = PRICE_W_DEF,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*SIZE_W-1:0]    req_size,
  output logic [N_REQ-1:0]           req_ready,
  output logic [SIZE_W-1:0]          lr_size,
  input  logic [PRICE_W-1:0]         lr_price,
  input  logic                       lr_rout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [PRICE_W-1:0]         rsp_price,
  output logic                       rsp_rout,
  output logic                       busy,
  output logic [CNT_W-1:0]           rout_count
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state;
  state_t          state_nx;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  pick;
  logic [N_REQ-1:0] grant;
  logic            any;
  logic [CW-1:0]   cnt;
  logic [SIZE_W-1:0] pick_size;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (pick),
    .any        (any)
  );

  always_comb begin
    pick_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) pick_size = req_size[i*SIZE_W +: SIZE_W];
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any) state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Pointer resets to the last slot so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(N_REQ - 1);
      gid        <= '0;
      cnt        <= '0;
      lr_size    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_price  <= '0;
      rsp_rout   <= 1'b0;
      rout_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            lr_size    <= pick_size;
            gid        <= pick;
            last_grant <= pick;
            cnt        <= CW'(SETTLE - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_price <= lr_price;
            rsp_rout  <= lr_rout;
            rsp_id    <= gid;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_rout && !(&rout_count))
              rout_count <= rout_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linreg_scheduler.sv
// Self-checking bench for linreg_scheduler with a 3*size+100 datapath stub.
module tb_linreg_scheduler;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int PW = 32;
  localparam int ST = 3;

  typedef struct {
    int          id;
    logic [31:0] price;
    logic        rout;
  } sb_t;

  typedef struct {
    int          id;
    logic [15:0] size;
    logic [31:0] price;
    logic        rout;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*SW-1:0] req_size;
  logic [N-1:0]  req_ready;
  logic [SW-1:0] lr_size;
  logic [PW-1:0] lr_price;
  logic          lr_rout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [PW-1:0] rsp_price;
  logic          rsp_rout;
  logic          busy;
  logic [1:0]    rout_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int pulses [N];
  logic vprev  = 1'b0;
  logic [N-1:0] granted_lat = '0;
  logic [N-1:0] hold = '0;
  sb_t  sb [$];
  int   grant_log [$];
  int   gcyc [$];
  sb_t  em;
  vec_t tbl [4];

  always #5 clk = ~clk;

  assign lr_price = 32'(lr_size) * 32'd3 + 32'd100;
  assign lr_rout  = (lr_size > 16'd1000);

  linreg_scheduler #(
    .N_REQ   (N),
    .SIZE_W  (SW),
    .PRICE_W (PW),
    .SETTLE  (ST),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_size   (req_size),
    .req_ready  (req_ready),
    .lr_size    (lr_size),
    .lr_price   (lr_price),
    .lr_rout    (lr_rout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_price  (rsp_price),
    .rsp_rout   (rsp_rout),
    .busy       (busy),
    .rout_count (rout_count)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic sb_t model(int id, logic [15:0] s);
    sb_t r;
    r.id    = id;
    r.price = 32'(s) * 32'd3 + 32'd100;
    r.rout  = (s > 16'd1000);
    return r;
  endfunction

  // Monitor: grant log, latency stamps, scoreboard pop on handshake.
  always @(negedge clk) begin
    cyc++;
    granted_lat = '0;
    if (rst_n) begin
      if (req_ready != '0) begin
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        granted_lat = req_ready;
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            grant_log.push_back(i);
            pulses[i]++;
          end
        end
        gcyc.push_back(cyc);
      end
      if (rsp_valid && !vprev) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("spurious_rsp", 64'(rsp_id), 64'd99);
        end else begin
          em = sb.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(em.id));
          check("rsp_price", 64'(rsp_price), 64'(em.price));
          check("rsp_rout", 64'(rsp_rout), 64'(em.rout));
        end
      end
    end
    vprev = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(granted_lat & ~hold);
  endtask

  task automatic set_req(int i, logic [15:0] s);
    req_size[i*SW +: SW] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_sb(int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    if (sb.size() != 0) check("rsp_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_grants(int want, int bound);
    int n = 0;
    while (grant_log.size() < want && n < bound) begin
      step();
      n++;
    end
    if (grant_log.size() < want)
      check("grant_timeout", 64'(grant_log.size()), 64'(want));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_size  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) pulses[i] = 0;
    tbl[0] = '{0, 16'd10, 32'd130, 1'b0};
    tbl[1] = '{1, 16'd20, 32'd160, 1'b0};
    tbl[2] = '{2, 16'd30, 32'd190, 1'b0};
    tbl[3] = '{3, 16'd40, 32'd220, 1'b0};

    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_lr_size", 64'(lr_size), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_price", 64'(rsp_price), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rout_count", 64'(rout_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    // Single request from requester 0.
    grant_log.delete();
    gcyc.delete();
    set_req(0, 16'd217);
    sb.push_back(model(0, 16'd217));
    wait_grants(1, 20);
    check("single_lr_size", 64'(lr_size), 64'd217);
    check("single_busy", 64'(busy), 64'd1);
    wait_sb(50);
    check("single_pulses", 64'(pulses[0]), 64'd1);
    if (gcyc.size() > 0)
      check("latency", 64'(rise_cyc - gcyc[0]), 64'(ST + 1));
    check("single_rout_count", 64'(rout_count), 64'd0);

    // All four requesters at once, after a reset to restore the pointer.
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_log.delete();
    gcyc.delete();
    foreach (tbl[r]) begin
      set_req(tbl[r].id, tbl[r].size);
      sb.push_back('{tbl[r].id, tbl[r].price, tbl[r].rout});
    end
    wait_sb(200);
    check("tbl_ngrants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check("tbl_order", 64'(grant_log[i]), 64'(i));
    for (int i = 1; i < gcyc.size() && i < 4; i++)
      check("tbl_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(ST + 2));

    // Backpressure with a second requester waiting.
    rsp_ready = 1'b0;
    set_req(2, 16'd500);
    set_req(3, 16'd7);
    sb.push_back(model(2, 16'd500));
    sb.push_back(model(3, 16'd7));
    for (int n = 0; n < 30 && !rsp_valid; n++) step();
    check("bp_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_price", 64'(rsp_price), 64'd1600);
      check("bp_id", 64'(rsp_id), 64'd2);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_next", 64'(req_ready), 64'b1000);
    wait_sb(100);

    // Fairness: requester 1 held, requester 2 raised once.
    grant_log.delete();
    hold[1] = 1'b1;
    set_req(1, 16'd50);
    set_req(2, 16'd60);
    sb.push_back(model(1, 16'd50));
    sb.push_back(model(2, 16'd60));
    sb.push_back(model(1, 16'd50));
    wait_grants(3, 60);
    hold = '0;
    req_valid[1] = 1'b0;
    wait_sb(100);
    if (grant_log.size() >= 3) begin
      check("fair_g0", 64'(grant_log[0]), 64'd1);
      check("fair_g1", 64'(grant_log[1]), 64'd2);
      check("fair_g2", 64'(grant_log[2]), 64'd1);
    end

    // rout events and counter saturation.
    for (int n = 1; n <= 5; n++) begin
      set_req(0, 16'd2000);
      sb.push_back(model(0, 16'd2000));
      wait_sb(50);
      check("rout_count", 64'(rout_count), 64'((n > 3) ? 3 : n));
    end

    // Reset in the middle of WAIT aborts the transaction.
    grant_log.delete();
    set_req(1, 16'd77);
    wait_grants(1, 20);
    check("abort_busy", 64'(busy), 64'd1);
    step();
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("abort_busy0", 64'(busy), 64'd0);
    check("abort_lr_size", 64'(lr_size), 64'd0);
    check("abort_valid", 64'(rsp_valid), 64'd0);
    check("abort_price", 64'(rsp_price), 64'd0);
    check("abort_count", 64'(rout_count), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd0);
    step();
    step();
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    grant_log.delete();
    set_req(0, 16'd5);
    set_req(2, 16'd6);
    sb.push_back(model(0, 16'd5));
    sb.push_back(model(2, 16'd6));
    wait_sb(100);
    if (grant_log.size() >= 2) begin
      check("post_rst_g0", 64'(grant_log[0]), 64'd0);
      check("post_rst_g1", 64'(grant_log[1]), 64'd2);
    end else begin
      check("post_rst_ngrants", 64'(grant_log.size()), 64'd2);
    end

    repeat (10) step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
